// File: rtl/seq_divider_pkg.sv
// seq_divider_pkg: shared types and helpers for the sequential divider.
//   div_state_t  - divider FSM states
//   MaxWidth     - widest operand the helpers below support
//   most_neg()   - most-negative two's-complement value of a given width
//   is_overflow()- detects the signed (most-negative / -1) overflow case
package seq_divider_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } div_state_t;

    localparam int unsigned MaxWidth = 128;

    // Only bit (w-1) set; callers slice the low w bits.
    function automatic logic [MaxWidth-1:0] most_neg(input int unsigned w);
        logic [MaxWidth-1:0] v;
        v = '0;
        v[w-1] = 1'b1;
        return v;
    endfunction

    // Operands are zero-extended to MaxWidth; only the low w bits matter.
    function automatic logic is_overflow(input logic [MaxWidth-1:0] a,
                                         input logic [MaxWidth-1:0] b,
                                         input logic                sgn,
                                         input int unsigned         w);
        logic a_min;
        logic b_ones;
        a_min  = 1'b1;
        b_ones = 1'b1;
        for (int unsigned i = 0; i < MaxWidth; i++) begin
            if (i < w) begin
                if (i == w - 1) a_min = a_min & a[i];
                else            a_min = a_min & ~a[i];
                b_ones = b_ones & b[i];
            end
        end
        return sgn & a_min & b_ones;
    endfunction

endpackage

// File: rtl/seq_divider_cla_adder.sv
// cla_adder: generate/propagate adder with optional subtract.
//   a, b  - operands (InputSize bits)
//   sub   - 1: sum = a - b (b inverted, carry-in 1); 0: sum = a + b
//   sum   - result
//   c_o   - carry out; in subtract mode 1 means a >= b (no borrow)
module cla_adder #(
    parameter int InputSize = 64
) (
    input  logic [InputSize-1:0] a,
    input  logic [InputSize-1:0] b,
    input  logic                 sub,
    output logic [InputSize-1:0] sum,
    output logic                 c_o
);

    logic [InputSize-1:0] bx;
    logic [InputSize-1:0] g;
    logic [InputSize-1:0] p;
    logic [InputSize:0]   c;

    always_comb begin
        bx   = b ^ {InputSize{sub}};
        g    = a & bx;
        p    = a ^ bx;
        c    = '0;
        c[0] = sub;
        for (int unsigned i = 0; i < InputSize; i++) begin
            c[i+1] = g[i] | (p[i] & c[i]);
        end
        sum = p ^ c[InputSize-1:0];
        c_o = c[InputSize];
    end

endmodule

// File: rtl/seq_divider.sv
// seq_divider: iterative radix-2 restoring divider (DIV/DIVU/REM/REMU).
//   clk, reset           - clock, asynchronous active-high reset
//   in_valid / in_ready  - operand handshake (in_ready high only in IDLE)
//   dividend, divisor    - operands; is_signed selects two's-complement
//   out_valid / out_ready- result handshake
//   quotient, remainder  - results; div_by_zero flags divisor == 0
// Build option: SEQ_DIVIDER_FAST_SPECIAL_EN sends divide-by-zero and signed
// overflow from IDLE straight to FIX instead of running the full CALC loop.
module seq_divider
    import seq_divider_pkg::*;
#(
    parameter int InputSize  = 64,
    parameter int CountWidth = $clog2(InputSize) + 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [InputSize-1:0] dividend,
    input  logic [InputSize-1:0] divisor,
    input  logic                 is_signed,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [InputSize-1:0] quotient,
    output logic [InputSize-1:0] remainder,
    output logic                 div_by_zero
);

    localparam logic [MaxWidth-1:0]  MostNegWide = most_neg(InputSize);
    localparam logic [InputSize-1:0] MostNeg     = MostNegWide[InputSize-1:0];

    div_state_t state_q, state_d;
    logic [CountWidth-1:0] cnt_q, cnt_d;
    logic [InputSize-1:0]  rem_q, rem_d;
    logic [InputSize-1:0]  quo_q, quo_d;
    logic [InputSize-1:0]  dvs_q, dvs_d;
    logic [InputSize-1:0]  a_q, a_d;
    logic                  q_neg_q, q_neg_d;
    logic                  r_neg_q, r_neg_d;
    logic                  dz_q, dz_d;
    logic                  ovf_q, ovf_d;
    logic [InputSize-1:0]  quotient_q, quotient_d;
    logic [InputSize-1:0]  remainder_q, remainder_d;
    logic                  dbz_q, dbz_d;
    logic                  out_valid_q, out_valid_d;

    logic [InputSize-1:0]  rem_sh;
    logic [InputSize-1:0]  trial;
    logic                  no_borrow;
    logic                  take;
    logic                  a_neg;
    logic                  b_neg;

    assign rem_sh = {rem_q[InputSize-2:0], quo_q[InputSize-1]};

    cla_adder #(.InputSize(InputSize)) u_trial_sub (
        .a   (rem_sh),
        .b   (dvs_q),
        .sub (1'b1),
        .sum (trial),
        .c_o (no_borrow)
    );

    // The bit shifted out of rem is the 2^InputSize weight of the partial
    // remainder; when set the trial always succeeds and trial's low bits
    // are still the correct difference.
    assign take = no_borrow | rem_q[InputSize-1];

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        rem_d       = rem_q;
        quo_d       = quo_q;
        dvs_d       = dvs_q;
        a_d         = a_q;
        q_neg_d     = q_neg_q;
        r_neg_d     = r_neg_q;
        dz_d        = dz_q;
        ovf_d       = ovf_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        dbz_d       = dbz_q;
        out_valid_d = 1'b0;
        a_neg       = is_signed & dividend[InputSize-1];
        b_neg       = is_signed & divisor[InputSize-1];

        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    rem_d   = '0;
                    quo_d   = a_neg ? -dividend : dividend;
                    dvs_d   = b_neg ? -divisor : divisor;
                    a_d     = dividend;
                    q_neg_d = a_neg ^ b_neg;
                    r_neg_d = a_neg;
                    dz_d    = (divisor == '0);
                    ovf_d   = is_overflow(MaxWidth'(dividend), MaxWidth'(divisor),
                                          is_signed, InputSize);
                    cnt_d   = CountWidth'(InputSize);
                    state_d = CALC;
`ifdef SEQ_DIVIDER_FAST_SPECIAL_EN
                    if (dz_d || ovf_d) state_d = FIX;
`endif
                end
            end
            CALC: begin
                quo_d = {quo_q[InputSize-2:0], take};
                rem_d = take ? trial : rem_sh;
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == CountWidth'(1)) state_d = FIX;
            end
            FIX: begin
                if (dz_q) begin
                    quotient_d  = '1;
                    remainder_d = a_q;
                    dbz_d       = 1'b1;
                end else if (ovf_q) begin
                    quotient_d  = MostNeg;
                    remainder_d = '0;
                    dbz_d       = 1'b0;
                end else begin
                    quotient_d  = q_neg_q ? -quo_q : quo_q;
                    remainder_d = r_neg_q ? -rem_q : rem_q;
                    dbz_d       = 1'b0;
                end
                state_d = DONE;
            end
            DONE: begin
                // out_valid rises one cycle after entering DONE; out_ready
                // only counts once the result is actually presented.
                if (out_valid_q && out_ready) begin
                    state_d = IDLE;
                end else begin
                    out_valid_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            rem_q       <= '0;
            quo_q       <= '0;
            dvs_q       <= '0;
            a_q         <= '0;
            q_neg_q     <= 1'b0;
            r_neg_q     <= 1'b0;
            dz_q        <= 1'b0;
            ovf_q       <= 1'b0;
            quotient_q  <= '0;
            remainder_q <= '0;
            dbz_q       <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rem_q       <= rem_d;
            quo_q       <= quo_d;
            dvs_q       <= dvs_d;
            a_q         <= a_d;
            q_neg_q     <= q_neg_d;
            r_neg_q     <= r_neg_d;
            dz_q        <= dz_d;
            ovf_q       <= ovf_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            dbz_q       <= dbz_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready    = (state_q == IDLE);
    assign out_valid   = out_valid_q;
    assign quotient    = quotient_q;
    assign remainder   = remainder_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_divider.sv
// tb_seq_divider: vector table, corner sequences and random regression for
// seq_divider, with a queue of expected results checked at each output.
module tb_seq_divider;

    localparam int W = 64;
    localparam logic [W-1:0] MINNEG = 64'h8000_0000_0000_0000;
    localparam logic [W-1:0] ONES   = 64'hFFFF_FFFF_FFFF_FFFF;
`ifdef SEQ_DIVIDER_FAST_SPECIAL_EN
    localparam int SPEC_LAT = 2;
`else
    localparam int SPEC_LAT = W + 2;
`endif

    logic         clk = 1'b0;
    logic         reset;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] dividend;
    logic [W-1:0] divisor;
    logic         is_signed;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         div_by_zero;

    seq_divider #(.InputSize(W)) dut (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .dividend    (dividend),
        .divisor     (divisor),
        .is_signed   (is_signed),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         s;
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         dz;
        logic         spec;
    } vec_t;

    typedef struct {
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         dz;
    } exp_t;

    vec_t vecs[13];
    exp_t sb[$];
    int   asserts = 0;
    int   fails   = 0;

    task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
        asserts++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Independent DIV/REM reference built on the language operators.
    function automatic exp_t ref_div(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
        exp_t e;
        e.dz = 1'b0;
        if (b == '0) begin
            e.q = ONES; e.r = a; e.dz = 1'b1;
        end else if (s && a == MINNEG && b == ONES) begin
            e.q = a; e.r = '0;
        end else if (s) begin
            e.q = $signed(a) / $signed(b);
            e.r = $signed(a) % $signed(b);
        end else begin
            e.q = a / b;
            e.r = a % b;
        end
        return e;
    endfunction

    task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                            input exp_t e);
        int n;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk("in_ready wait", {63'd0, in_ready}, 64'd1);
        dividend  = a;
        divisor   = b;
        is_signed = s;
        in_valid  = 1'b1;
        sb.push_back(e);
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        dividend  = 64'hDEAD_BEEF_0BAD_F00D;
        divisor   = 64'h0;
        is_signed = ~s;
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        while (!out_valid && n < 300) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("out_valid wait", {63'd0, out_valid}, 64'd1);
    endtask

    task automatic check_out(input string nm, input int lat, input int n);
        exp_t e;
        if (lat > 0) chk({nm, " latency"}, 64'(n), 64'(lat));
        if (sb.size() == 0) begin
            chk({nm, " scoreboard empty"}, 64'd1, 64'd0);
        end else begin
            e = sb.pop_front();
            chk({nm, " quotient"}, quotient, e.q);
            chk({nm, " remainder"}, remainder, e.r);
            chk({nm, " div_by_zero"}, {63'd0, div_by_zero}, {63'd0, e.dz});
        end
    endtask

    task automatic handshake();
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    task automatic run_op(input string nm, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic s, input exp_t e, input int lat);
        int n;
        start_op(a, b, s, e);
        wait_valid(n);
        check_out(nm, lat, n);
        handshake();
    endtask

    initial begin
        exp_t e;
        int   n;
        logic [W-1:0] hq, hr;
        logic [W-1:0] ra, rb;
        logic         rs;

        vecs[0]  = '{64'd100, 64'd7, 1'b0, 64'd14, 64'd2, 1'b0, 1'b0};
        vecs[1]  = '{-64'sd100, 64'd7, 1'b1, 64'hFFFF_FFFF_FFFF_FFF2, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0};
        vecs[2]  = '{64'd100, -64'sd7, 1'b1, 64'hFFFF_FFFF_FFFF_FFF2, 64'd2, 1'b0, 1'b0};
        vecs[3]  = '{64'h1234, 64'd0, 1'b1, ONES, 64'h1234, 1'b1, 1'b1};
        vecs[4]  = '{64'h1234, 64'd0, 1'b0, ONES, 64'h1234, 1'b1, 1'b1};
        vecs[5]  = '{MINNEG, ONES, 1'b1, MINNEG, 64'd0, 1'b0, 1'b1};
        vecs[6]  = '{MINNEG, ONES, 1'b0, 64'd0, MINNEG, 1'b0, 1'b0};
        vecs[7]  = '{-64'sd100, -64'sd7, 1'b1, 64'd14, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0};
        vecs[8]  = '{ONES, 64'd1, 1'b0, ONES, 64'd0, 1'b0, 1'b0};
        vecs[9]  = '{ONES, ONES, 1'b0, 64'd1, 64'd0, 1'b0, 1'b0};
        vecs[10] = '{64'd7, 64'd100, 1'b0, 64'd0, 64'd7, 1'b0, 1'b0};
        vecs[11] = '{ONES, 64'd2, 1'b1, 64'd0, ONES, 1'b0, 1'b0};
        vecs[12] = '{MINNEG, 64'd1, 1'b1, MINNEG, 64'd0, 1'b0, 1'b0};

        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        dividend = '0; divisor = '0; is_signed = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset in_ready", {63'd0, in_ready}, 64'd1);
        chk("reset out_valid", {63'd0, out_valid}, 64'd0);
        chk("reset quotient", quotient, 64'd0);
        chk("reset remainder", remainder, 64'd0);
        chk("reset div_by_zero", {63'd0, div_by_zero}, 64'd0);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 13; i++) begin
            e.q = vecs[i].q; e.r = vecs[i].r; e.dz = vecs[i].dz;
            run_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].s, e,
                   vecs[i].spec ? SPEC_LAT : W + 2);
            chk($sformatf("vec%0d out_valid drop", i), {63'd0, out_valid}, 64'd0);
            chk($sformatf("vec%0d in_ready back", i), {63'd0, in_ready}, 64'd1);
        end

        // Backpressure: hold result 10 cycles while a new request is offered.
        out_ready = 1'b1;
        e.q = 64'd142; e.r = 64'd6; e.dz = 1'b0;
        out_ready = 1'b0;
        start_op(64'd1000, 64'd7, 1'b0, e);
        out_ready = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk("early out_ready ignored", {63'd0, out_valid}, 64'd0);
        wait_valid(n);
        hq = quotient; hr = remainder;
        check_out("bp", 0, 0);
        in_valid = 1'b1; dividend = 64'd9; divisor = 64'd3; is_signed = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk);
            #1;
            chk("bp hold valid", {63'd0, out_valid}, 64'd1);
            chk("bp hold quotient", quotient, hq);
            chk("bp hold remainder", remainder, hr);
            chk("bp in_ready low", {63'd0, in_ready}, 64'd0);
        end
        in_valid = 1'b0;
        handshake();
        chk("bp no extra op", {63'd0, in_ready}, 64'd1);

        // Asynchronous reset in the middle of CALC discards the operation.
        e.q = 64'd1; e.r = 64'd0; e.dz = 1'b0;
        start_op(64'h1234_5678, 64'd3, 1'b0, e);
        repeat (29) @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        void'(sb.pop_back());
        chk("mid reset in_ready", {63'd0, in_ready}, 64'd1);
        chk("mid reset out_valid", {63'd0, out_valid}, 64'd0);
        chk("mid reset quotient", quotient, 64'd0);
        chk("mid reset remainder", remainder, 64'd0);
        @(negedge clk);
        reset = 1'b0;
        e.q = 64'd10; e.r = 64'd0; e.dz = 1'b0;
        run_op("after reset", 64'd50, 64'd5, 1'b0, e, W + 2);

        for (int i = 0; i < 1000; i++) begin
            ra = {$urandom, $urandom};
            case ($urandom_range(0, 3))
                0: rb = 64'($urandom_range(0, 20));
                1: rb = {32'd0, $urandom};
                2: rb = -64'($urandom_range(1, 20));
                default: rb = {$urandom, $urandom};
            endcase
            rs = 1'($urandom_range(0, 1));
            run_op("rand", ra, rb, rs, ref_div(ra, rb, rs), 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
        $finish;
    end

endmodule
